// File: rtl/laser_rx_buffer.sv
// -----------------------------------------------------------------------------
// laser_rx_buffer
//
// Receive FIFO for a two-lane laser receiver. Each rising edge of data_valid
// captures one byte pair {data1_in, data2_in} into a first-word fall-through
// FIFO. If a pair arrives while the FIFO is full, it is dropped and the sticky
// overflow flag is set.
//
// Optional feature macro: LASER_RX_BUFFER_STATS_EN
//   defined   : accepted_count / dropped_count are saturating event counters
//   undefined : both outputs are tied to zero and no counter logic exists
//
// Parameters
//   DEPTH          FIFO entries, power of two, 2..256
//
// Ports
//   clock          single clock for all state
//   reset          asynchronous, active-high reset
//   data_valid     level from the receiver; a rising edge requests a push
//   data1_in       lane-1 received byte
//   data2_in       lane-2 received byte
//   rd_en          consumer pop request (ignored while empty)
//   flush          synchronous clear of pointers and count
//   clear_ovf      synchronous clear of overflow (a new overflow wins)
//   dout           head entry {lane1, lane2}, 16'h0000 while empty
//   empty / full   occupancy flags
//   count          current entry count
//   overflow       sticky drop flag
//   accepted_count accepted-push counter (stats build only)
//   dropped_count  dropped-push counter (stats build only)
// -----------------------------------------------------------------------------
module laser_rx_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   data_valid,
  input  logic [7:0]             data1_in,
  input  logic [7:0]             data2_in,
  input  logic                   rd_en,
  input  logic                   flush,
  input  logic                   clear_ovf,
  output logic [15:0]            dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            accepted_count,
  output logic [15:0]            dropped_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          data_valid_q;

  logic push_req;
  logic do_push;
  logic do_pop;
  logic do_drop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A push is a rising edge of data_valid. Flush overrides every queue
  // operation in its cycle. A pop frees a slot, so a full FIFO still accepts
  // a push in the same cycle; a pop on an empty FIFO is ignored.
  assign push_req = data_valid & ~data_valid_q & ~flush;
  assign do_pop   = rd_en & ~empty & ~flush;
  assign do_push  = push_req & (~full | do_pop);
  assign do_drop  = push_req & full & ~do_pop;

  assign dout = empty ? 16'h0000 : mem[rd_ptr];

  // data_valid_q resets high so a level held across reset release is not
  // treated as a rising edge.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_valid_q <= 1'b1;
    end else begin
      data_valid_q <= data_valid;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale contents are unreachable
  // because dout is forced to zero while empty and pointers do reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= {data1_in, data2_in};
  end

  // Setting takes priority over clearing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (do_drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef LASER_RX_BUFFER_STATS_EN
  // Saturating counters; flush does not clear them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      accepted_count <= '0;
      dropped_count  <= '0;
    end else begin
      if (do_push && accepted_count != 16'hFFFF) accepted_count <= accepted_count + 16'd1;
      if (do_drop && dropped_count  != 16'hFFFF) dropped_count  <= dropped_count  + 16'd1;
    end
  end
`else
  assign accepted_count = 16'h0000;
  assign dropped_count  = 16'h0000;
`endif

endmodule

// File: doc/laser_rx_buffer.md
LASER_RX_BUFFER -- requirements
Module: laser_rx_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 2 to 256.
REQ-002 clock  input  1  single clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_valid  input  1  level from the laser receiver; high while data1_in/data2_in hold a received byte pair.
REQ-005 data1_in  input  8  lane-1 received byte.
REQ-006 data2_in  input  8  lane-2 received byte.
REQ-007 rd_en  input  1  consumer pop request.
REQ-008 flush  input  1  synchronous FIFO clear.
REQ-009 clear_ovf  input  1  synchronous clear of overflow.
REQ-010 dout  output  16  head entry, {lane1 byte, lane2 byte}.
REQ-011 empty  output  1  FIFO holds zero entries.
REQ-012 full  output  1  FIFO holds DEPTH entries.
REQ-013 count  output  $clog2(DEPTH)+1  current entry count.
REQ-014 overflow  output  1  sticky flag; a byte pair was dropped.
REQ-015 accepted_count, dropped_count  output  16 each  statistics counters (see Configuration).

Function
REQ-016 The block SHALL register data_valid into data_valid_q every cycle; push = data_valid & ~data_valid_q (one push per rising edge of data_valid).
REQ-017 On push with not full, {data1_in, data2_in} sampled at that edge SHALL be written at wr_ptr, and wr_ptr SHALL increment modulo DEPTH.
REQ-018 On rd_en with not empty, rd_ptr SHALL increment modulo DEPTH; rd_en while empty SHALL be ignored, with no state change.
REQ-019 dout SHALL show the entry at rd_ptr (first-word fall-through) while not empty, and 16'h0000 while empty.
REQ-020 Latency: a push at clock edge k SHALL make empty low and dout valid after edge k (one cycle from the data_valid rise being sampled).
REQ-021 Push and pop in the same cycle while full SHALL both take effect; count stays DEPTH, full stays high, overflow unchanged.
REQ-022 Push and pop in the same cycle while empty SHALL accept the push and ignore the pop; count becomes 1.
REQ-023 Push while full without a simultaneous pop SHALL drop the pair and set overflow.
REQ-024 overflow SHALL remain set until clear_ovf; a set in the same cycle as clear_ovf SHALL win.
REQ-025 flush SHALL zero wr_ptr, rd_ptr and count on the next edge, and SHALL override push and pop in that cycle; overflow is unaffected.
REQ-026 count SHALL track pushes minus pops exactly; empty = (count==0), full = (count==DEPTH).

Reset
REQ-027 reset SHALL asynchronously force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, dout=16'h0000, accepted_count=0, dropped_count=0.
REQ-028 data_valid_q SHALL reset to 1, so a data_valid level held through reset release is not captured.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; no push SHALL occur until data_valid has been seen low after release.

Configuration
REQ-030 Macro LASER_RX_BUFFER_STATS_EN defined: accepted_count SHALL increment on each accepted push, and dropped_count SHALL increment on each dropped push; both saturate at 16'hFFFF and are not cleared by flush.
REQ-031 Macro LASER_RX_BUFFER_STATS_EN undefined: accepted_count and dropped_count SHALL be constant 0, and no counter logic SHALL be synthesized.

Verification
REQ-032 Reset, then three data_valid pulses with pairs 12/34, C8/77, AB/CD, then three rd_en -> dout 1234, C877, ABCD in order; empty after the third pop; count 3 to 0.
REQ-033 data_valid held high for 10 cycles with 12/34 -> exactly one entry; count=1.
REQ-034 17 pushes into DEPTH=16 -> full=1, count=16, overflow=1, 17th pair absent; with STATS_EN, dropped_count=1 and accepted_count=16.
REQ-035 Full FIFO plus simultaneous push and rd_en -> count stays 16, overflow stays 0, new pair at tail; rd_en on empty FIFO -> no change, dout=0000.
REQ-036 data_valid high across reset deassertion -> no push; then drop, raise with 55/AA -> one entry 55AA. flush with 5 entries -> count=0, empty=1 next cycle, overflow unchanged.
REQ-037 Push 40 entries with interleaved pops, never exceeding 16 held -> pointers wrap, data order preserved, overflow=0.
